// File: rtl/output_hold_driver_pkg.sv
// Shared definitions for the output hold driver: FSM state encoding,
// default minimum hold lengths and a small constant helper.
package output_hold_driver_pkg;

    // Two idle states hold the settled level; two hold states enforce the
    // minimum time a newly driven level must stay on the pin.
    typedef enum logic [1:0] {
        OFF_IDLE = 2'd0,
        ON_HOLD  = 2'd1,
        ON_IDLE  = 2'd2,
        OFF_HOLD = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_MIN_ON_CYCLES  = 2_000_000;
    localparam int unsigned DEFAULT_MIN_OFF_CYCLES = 2_000_000;

    // Larger of two cycle counts; sizes the shared hold counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/output_hold_driver_if.sv
// Request / drive bundle of the output hold driver.
//
// Handshake: there is no valid/ready pair. req is a level, sampled on every
// rising clk edge; drive, busy and changed are registered levels that are
// valid in every cycle. state is a debug copy of the FSM state register.
interface output_hold_driver_if;
    import output_hold_driver_pkg::*;

    logic   req;
    logic   drive;
    logic   busy;
    logic   changed;
    state_t state;

    // Requester side: supplies req, observes the driven level.
    modport master (
        output req,
        input  drive,
        input  busy,
        input  changed,
        input  state
    );

    // Driver side: consumes req, produces the registered outputs.
    modport slave (
        input  req,
        output drive,
        output busy,
        output changed,
        output state
    );

endinterface

// File: rtl/output_hold_driver_hold_timer.sv
// hold_timer: up-counter for the minimum-hold windows. Cleared to 0
// synchronously (clear_n low), counts while enabled, and saturates at
// FINAL_VALUE so it can never wrap inside a window.
module hold_timer #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned FINAL_VALUE = 1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    localparam logic [WIDTH-1:0] FINAL = WIDTH'(FINAL_VALUE);

    logic [WIDTH-1:0] count_q;

    // Counter register: clear wins, then count up until FINAL is reached.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            count_q <= '0;
        end else if (en && (count_q != FINAL)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
    assign done  = (count_q == FINAL);

endmodule

// File: rtl/output_hold_driver.sv
// output_hold_driver: drives an off-chip level (relay, LED, actuator) from a
// clean request, guaranteeing each new level stays put for a minimum number
// of cycles. Request changes inside a hold window are ignored except for the
// value seen in the window's final cycle.
module output_hold_driver
    import output_hold_driver_pkg::*;
#(
    parameter int unsigned MIN_ON_CYCLES  = DEFAULT_MIN_ON_CYCLES,
    parameter int unsigned MIN_OFF_CYCLES = DEFAULT_MIN_OFF_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output_hold_driver_if.slave  bus
);

    localparam int unsigned MAX_CYCLES = max_u(MIN_ON_CYCLES, MIN_OFF_CYCLES);
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             hold_end;
    logic             in_hold;
    logic             timer_clear_n;
    logic             drive_q;
    logic             busy_q;
    logic             changed_q;

    // One shared counter times both windows; it saturates at the longer one.
    hold_timer #(
        .WIDTH       (CNT_W),
        .FINAL_VALUE (MAX_CYCLES - 1)
    ) u_hold_timer (
        .clk     (clk),
        .clear_n (timer_clear_n),
        .en      (in_hold),
        .count   (count),
        .done    (done)
    );

    // Next-state logic and timer control.
    always_comb begin
        next_state    = state;
        hold_end      = 1'b0;
        in_hold       = (state == ON_HOLD) || (state == OFF_HOLD);
        case (state)
            OFF_IDLE: begin
                if (bus.req) next_state = ON_HOLD;
            end
            ON_HOLD: begin
                // done can only be reached here if ON is the longer window.
                hold_end = done || (count == ON_LAST);
                if (hold_end) next_state = bus.req ? ON_IDLE : OFF_HOLD;
            end
            ON_IDLE: begin
                if (!bus.req) next_state = OFF_HOLD;
            end
            OFF_HOLD: begin
                hold_end = done || (count == OFF_LAST);
                if (hold_end) next_state = bus.req ? ON_HOLD : OFF_IDLE;
            end
            default: next_state = OFF_IDLE;
        endcase
        // Keep counting only while staying in the same hold state; any entry
        // into a hold, any idle cycle and reset restart it from 0.
        timer_clear_n = reset_n && in_hold && (next_state == state);
    end

    // State and output registers; outputs are decoded from the next state so
    // they line up with the state register and carry no path from req.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= OFF_IDLE;
            drive_q   <= 1'b0;
            busy_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state     <= next_state;
            drive_q   <= (next_state == ON_HOLD) || (next_state == ON_IDLE);
            busy_q    <= (next_state == ON_HOLD) || (next_state == OFF_HOLD);
            changed_q <= (next_state != state) &&
                         ((next_state == ON_HOLD) || (next_state == OFF_HOLD));
        end
    end

    assign bus.drive   = drive_q;
    assign bus.busy    = busy_q;
    assign bus.changed = changed_q;
    assign bus.state   = state;

endmodule

// File: tb/tb_output_hold_driver.sv
// Directed bench for output_hold_driver with MIN_ON_CYCLES=4, MIN_OFF_CYCLES=3,
// followed by a random-request phase that measures run lengths.
module tb_output_hold_driver;
    import output_hold_driver_pkg::*;

    localparam int unsigned MIN_ON  = 4;
    localparam int unsigned MIN_OFF = 3;

    logic clk;
    logic reset_n;

    int n_vec;
    int n_bad;

    output_hold_driver_if dif ();

    output_hold_driver #(
        .MIN_ON_CYCLES  (MIN_ON),
        .MIN_OFF_CYCLES (MIN_OFF)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dif.slave)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply req for one clock edge, then check outputs just after the edge.
    task automatic step(input logic r, input logic ed, input logic eb,
                        input logic ec, input state_t es, input string tag);
        dif.req = r;
        @(posedge clk);
        #1;
        check({tag, ".drive"},   32'(dif.drive),   32'(ed));
        check({tag, ".busy"},    32'(dif.busy),    32'(eb));
        check({tag, ".changed"}, 32'(dif.changed), 32'(ec));
        check({tag, ".state"},   32'(dif.state),   32'(es));
    endtask

    initial begin
        int     hi_min;
        int     lo_min;
        int     run_len;
        int     edges;
        int     pulses;
        int     seg_left;
        logic   seg_lvl;
        logic   prev;
        bit     first_run;

        n_vec   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        dif.req = 1'b0;

        // Reset state.
        @(posedge clk);
        step(0, 0, 0, 0, OFF_IDLE, "reset");

        // Request from reset: ON_HOLD for cycles 1-4, then ON_IDLE.
        reset_n = 1'b1;
        step(1, 1, 1, 1, ON_HOLD, "on_c1");
        step(1, 1, 1, 0, ON_HOLD, "on_c2");
        step(1, 1, 1, 0, ON_HOLD, "on_c3");
        step(1, 1, 1, 0, ON_HOLD, "on_c4");
        step(1, 1, 0, 0, ON_IDLE, "on_c5");
        step(1, 1, 0, 0, ON_IDLE, "on_c6");

        // One-cycle low request from ON_IDLE: low exactly 3 cycles, then
        // straight back into ON_HOLD.
        step(0, 0, 1, 1, OFF_HOLD, "dip_l1");
        step(1, 0, 1, 0, OFF_HOLD, "dip_l2");
        step(1, 0, 1, 0, OFF_HOLD, "dip_l3");
        step(1, 1, 1, 1, ON_HOLD,  "dip_h1");
        step(1, 1, 1, 0, ON_HOLD,  "dip_h2");
        step(1, 1, 1, 0, ON_HOLD,  "dip_h3");
        step(1, 1, 1, 0, ON_HOLD,  "dip_h4");
        step(1, 1, 0, 0, ON_IDLE,  "dip_idle");

        // Go low; a short high pulse inside OFF_HOLD must be ignored.
        step(0, 0, 1, 1, OFF_HOLD, "pulse_l1");
        step(1, 0, 1, 0, OFF_HOLD, "pulse_l2");
        step(0, 0, 1, 0, OFF_HOLD, "pulse_l3");
        step(0, 0, 0, 0, OFF_IDLE, "pulse_idle");

        // One-cycle request from OFF_IDLE: high exactly 4 cycles, OFF_HOLD 3.
        step(1, 1, 1, 1, ON_HOLD,  "blip_h1");
        step(0, 1, 1, 0, ON_HOLD,  "blip_h2");
        step(0, 1, 1, 0, ON_HOLD,  "blip_h3");
        step(0, 1, 1, 0, ON_HOLD,  "blip_h4");
        step(0, 0, 1, 1, OFF_HOLD, "blip_l1");
        step(0, 0, 1, 0, OFF_HOLD, "blip_l2");
        step(0, 0, 1, 0, OFF_HOLD, "blip_l3");
        step(0, 0, 0, 0, OFF_IDLE, "blip_idle");

        // Toggle req every cycle of ON_HOLD, ending high: stay on.
        step(1, 1, 1, 1, ON_HOLD, "tog_h1");
        step(0, 1, 1, 0, ON_HOLD, "tog_h2");
        step(1, 1, 1, 0, ON_HOLD, "tog_h3");
        step(0, 1, 1, 0, ON_HOLD, "tog_h4");
        step(1, 1, 0, 0, ON_IDLE, "tog_idle");

        // Reset in cycle 2 of ON_HOLD aborts the window; a fresh window
        // starts one cycle after release.
        step(0, 0, 1, 1, OFF_HOLD, "rh_l1");
        step(0, 0, 1, 0, OFF_HOLD, "rh_l2");
        step(0, 0, 1, 0, OFF_HOLD, "rh_l3");
        step(0, 0, 0, 0, OFF_IDLE, "rh_idle");
        step(1, 1, 1, 1, ON_HOLD,  "rh_h1");
        step(1, 1, 1, 0, ON_HOLD,  "rh_h2");
        reset_n = 1'b0;
        step(1, 0, 0, 0, OFF_IDLE, "rh_reset");
        reset_n = 1'b1;
        step(1, 1, 1, 1, ON_HOLD,  "rh_re1");
        step(1, 1, 1, 0, ON_HOLD,  "rh_re2");
        step(1, 1, 1, 0, ON_HOLD,  "rh_re3");
        step(1, 1, 1, 0, ON_HOLD,  "rh_re4");
        step(1, 1, 0, 0, ON_IDLE,  "rh_re_idle");

        // Random request segments; measure every complete drive run.
        hi_min    = 1_000_000;
        lo_min    = 1_000_000;
        run_len   = 0;
        edges     = 0;
        pulses    = 0;
        seg_left  = 0;
        seg_lvl   = 1'b0;
        prev      = dif.drive;
        first_run = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (seg_left == 0) begin
                seg_lvl  = 1'($urandom_range(0, 1));
                seg_left = $urandom_range(1, 8);
            end
            dif.req = seg_lvl;
            seg_left--;
            @(posedge clk);
            #1;
            if (dif.changed === 1'b1) pulses++;
            if (dif.drive !== prev) begin
                edges++;
                if (!first_run) begin
                    if (prev === 1'b1) begin
                        if (run_len < hi_min) hi_min = run_len;
                    end else begin
                        if (run_len < lo_min) lo_min = run_len;
                    end
                end
                first_run = 1'b0;
                run_len   = 1;
                prev      = dif.drive;
            end else begin
                run_len++;
            end
        end
        check("rand_edges_seen",    32'(edges > 20), 32'd1);
        check("rand_min_high_ge_4", 32'(hi_min >= int'(MIN_ON)), 32'd1);
        check("rand_min_low_ge_3",  32'(lo_min >= int'(MIN_OFF)), 32'd1);
        check("rand_changed_count", 32'(pulses), 32'(edges));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/output_hold_driver.md
OUTPUT_HOLD_DRIVER -- requirements
Module: output_hold_driver

Interface
REQ-001 Parameter MIN_ON_CYCLES, default 2_000_000: minimum number of cycles drive SHALL stay high once asserted; legal range >= 2.
REQ-002 Parameter MIN_OFF_CYCLES, default 2_000_000: minimum number of cycles drive SHALL stay low once deasserted; legal range >= 2.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 req  input  1  clean, synchronous requested output level (e.g. debounced command).
REQ-006 drive  output  1  registered output level sent off-chip (relay/LED/actuator).
REQ-007 busy  output  1  high while a minimum-hold window is running.
REQ-008 changed  output  1  one-cycle pulse in the first cycle of each new drive level.

Function
REQ-009 The FSM SHALL have exactly four states: OFF_IDLE, ON_HOLD, ON_IDLE, OFF_HOLD.
REQ-010 drive SHALL be 1 in ON_HOLD and ON_IDLE, and 0 in OFF_IDLE and OFF_HOLD; busy SHALL be 1 in ON_HOLD and OFF_HOLD only.
REQ-011 OFF_IDLE with req=1 SHALL go to ON_HOLD next cycle; otherwise stay.
REQ-012 ON_IDLE with req=0 SHALL go to OFF_HOLD next cycle; otherwise stay.
REQ-013 Latency: from an idle state, drive SHALL change exactly 1 cycle after the edge where req was sampled at the opposite level.
REQ-014 Hold counter SHALL be 0 in the first cycle of a hold state and increment by 1 per cycle while in that state.
REQ-015 ON_HOLD SHALL exit when counter == MIN_ON_CYCLES-1: to ON_IDLE if req=1, or directly to OFF_HOLD if req=0 that cycle.
REQ-016 OFF_HOLD SHALL exit when counter == MIN_OFF_CYCLES-1: to OFF_IDLE if req=0, or directly to ON_HOLD if req=1 that cycle.
REQ-017 As a result, each drive level SHALL last at least MIN_ON_CYCLES (high) or MIN_OFF_CYCLES (low) cycles, with no exception.
REQ-018 req changes during a hold window SHALL be ignored except for the value sampled in the final hold cycle; pulses shorter than the window and returning before its end SHALL produce no drive change.
REQ-019 changed SHALL be 1 in exactly the first cycle of ON_HOLD and of OFF_HOLD, and 0 otherwise.
REQ-020 Counter width SHALL be clog2(max(MIN_ON_CYCLES, MIN_OFF_CYCLES)); the counter SHALL never wrap within a hold window.
REQ-021 The counter SHALL be held at 0 in both idle states.

Reset
REQ-022 With reset_n=0 at a clock edge: state SHALL go to OFF_IDLE, the counter to 0, drive=0, busy=0 and changed=0 at that edge.
REQ-023 Reset mid-hold SHALL abort the window immediately; no hold time SHALL be enforced across reset.
REQ-024 In the first cycle after reset release, req=1 SHALL be treated like any OFF_IDLE request, so drive=1 one cycle later.

Structure
REQ-025 The state encoding constants and the default hold values SHALL live in the shared package/include used by the FSM-application blocks.
REQ-026 The counter SHALL be a sub-module, hold_timer (parameter FINAL_VALUE, synchronous active-low clear, enable, done output), instantiated once and cleared by the FSM on each hold entry.
REQ-027 drive, busy and changed SHALL be driven from registered state with no combinational path from req.

Verification (MIN_ON_CYCLES=4, MIN_OFF_CYCLES=3)
REQ-028 Reset, then req=1 at cycle 0 -> drive=1 and changed=1 at cycle 1; busy=1 for cycles 1-4; drive stays 1.
REQ-029 Drive high (ON_IDLE), req 1->0->1 for one cycle -> drive low for exactly 3 cycles, then high again with changed pulses at both edges.
REQ-030 req=1 for 1 cycle from OFF_IDLE -> drive high exactly 4 cycles, then OFF_HOLD for 3 cycles, then OFF_IDLE.
REQ-031 In ON_HOLD, toggle req every cycle, ending with 1 at the final hold cycle -> drive stays 1 and the state goes to ON_IDLE.
REQ-032 reset_n=0 in cycle 2 of ON_HOLD -> drive=0, busy=0 at that edge; req=1 after release -> drive=1 one cycle later.
REQ-033 Random req over 10k cycles -> every observed drive high run is >= 4 cycles, every low run is >= 3 cycles, and the changed pulse count equals the drive edge count.
